// File: rtl/stg2id_hs_pkg.sv
// stg2id_hs_pkg: opcode map, decode bus layout and occupancy states
// shared by the decode stage, its decoder and later dual-issue variants.
package stg2id_hs_pkg;

  localparam int SIZE_ADDR = 32;
  localparam int SIZE_DATA = 32;

  localparam int OPC_W   = 6;
  localparam int GP_W    = 5;
  localparam int SR_W    = 3;
  localparam int IMM_W   = 12;
  localparam int IMMSR_W = 16;
  localparam int CC_W    = 4;

  // Instruction word: opc[31:26] rd[25:21] rs[20:16] imm[11:0]
  // branch cc[25:22], srmov tgt_sr[23:21], srjcc src_sr[18:16] immsr[15:0]
  localparam logic [OPC_W-1:0] OPC_R_ADD   = 6'h01;
  localparam logic [OPC_W-1:0] OPC_R_SUB   = 6'h02;
  localparam logic [OPC_W-1:0] OPC_R_CMP   = 6'h03;
  localparam logic [OPC_W-1:0] OPC_I_ADDi  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_I_SUBi  = 6'h09;
  localparam logic [OPC_W-1:0] OPC_I_CMPi  = 6'h0A;
  localparam logic [OPC_W-1:0] OPC_B_BCC   = 6'h10;
  localparam logic [OPC_W-1:0] OPC_S_SRMOV = 6'h18;
  localparam logic [OPC_W-1:0] OPC_S_SRJCC = 6'h19;

  // Packed decode bus, MSB first
  typedef struct packed {
    logic               sgn_en;
    logic               imm_en;
    logic [IMM_W-1:0]   imm_val;
    logic [IMMSR_W-1:0] immsr_val;
    logic [CC_W-1:0]    cc;
    logic [GP_W-1:0]    tgt_gp;
    logic               tgt_gp_we;
    logic [SR_W-1:0]    tgt_sr;
    logic               tgt_sr_we;
    logic [GP_W-1:0]    src_gp;
    logic [SR_W-1:0]    src_sr;
  } dec_t;

  localparam int SIZE_DEC = $bits(dec_t);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/stg2id_hs_id_decode.sv
// stg2id_hs_id_decode: combinational instr -> packed decode bus.
// Ports: iw_instr in; ow_dec, ow_illegal out. Unused fields are zero.
module stg2id_hs_id_decode
  import stg2id_hs_pkg::*;
#(
  parameter int DATA_W = SIZE_DATA
) (
  input  logic [DATA_W-1:0] iw_instr,
  output dec_t              ow_dec,
  output logic              ow_illegal
);

  logic [OPC_W-1:0] opc;
  logic cls_r, cls_i, cls_b, cls_mov, cls_jcc;
  logic is_cmp, is_sgn;

  assign opc = iw_instr[31:26];

  assign cls_r = (opc == OPC_R_ADD) | (opc == OPC_R_SUB)
               | (opc == OPC_R_CMP);
  assign cls_i = (opc == OPC_I_ADDi) | (opc == OPC_I_SUBi)
               | (opc == OPC_I_CMPi);
  assign cls_b   = (opc == OPC_B_BCC);
  assign cls_mov = (opc == OPC_S_SRMOV);
  assign cls_jcc = (opc == OPC_S_SRJCC);

  assign is_cmp = (opc == OPC_R_CMP) | (opc == OPC_I_CMPi);
  assign is_sgn = is_cmp | (opc == OPC_R_SUB)
                | (opc == OPC_I_SUBi);

  always_comb begin
    ow_dec     = '0;
    ow_illegal = 1'b0;
    unique case (1'b1)
      cls_r: begin
        ow_dec.sgn_en    = is_sgn;
        ow_dec.tgt_gp    = iw_instr[25:21];
        ow_dec.tgt_gp_we = !is_cmp;
        ow_dec.src_gp    = iw_instr[20:16];
      end
      cls_i: begin
        ow_dec.sgn_en    = is_sgn;
        ow_dec.imm_en    = 1'b1;
        ow_dec.imm_val   = iw_instr[11:0];
        ow_dec.tgt_gp    = iw_instr[25:21];
        ow_dec.tgt_gp_we = !is_cmp;
      end
      cls_b: begin
        // branch offset is signed
        ow_dec.sgn_en  = 1'b1;
        ow_dec.imm_en  = 1'b1;
        ow_dec.imm_val = iw_instr[11:0];
        ow_dec.cc      = iw_instr[25:22];
      end
      cls_mov: begin
        ow_dec.tgt_sr    = iw_instr[23:21];
        ow_dec.tgt_sr_we = 1'b1;
        ow_dec.src_gp    = iw_instr[20:16];
      end
      cls_jcc: begin
        ow_dec.immsr_val = iw_instr[15:0];
        ow_dec.cc        = iw_instr[25:22];
        ow_dec.src_sr    = iw_instr[18:16];
      end
      default: ow_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/stg2id_hs.sv
// stg2id_hs: decode stage with valid/ready, skid entry, flush and
// saturating bubble counter. Upstream iw_valid/ow_ready, downstream ow_valid/iw_ready.
module stg2id_hs
  import stg2id_hs_pkg::*;
#(
  parameter int ADDR_W  = SIZE_ADDR,
  parameter int DATA_W  = SIZE_DATA,
  parameter int DEC_W   = SIZE_DEC,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_valid,
  output logic              ow_ready,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  output logic              ow_valid,
  input  logic              iw_ready,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [DEC_W-1:0]  ow_dec,
  output logic              ow_illegal,
  input  logic              iw_flush,
  output logic [CNT_W-1:0]  ow_bubble_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DEC_W-1:0]  dec;
    logic              ill;
  } ent_t;

  dec_t dec_s;
  logic ill_s;
  ent_t in_e, out_q, skid_q;
  occ_e st_q, st_d;
  logic rdy_q, vld, acc, ret;
  logic ld_out, ld_skid, pop_skid;
  logic [CNT_W-1:0] cnt_q;
  logic bub_inc;

  stg2id_hs_id_decode #(
    .DATA_W(DATA_W)
  ) u_dec (
    .iw_instr  (iw_instr),
    .ow_dec    (dec_s),
    .ow_illegal(ill_s)
  );

  always_comb begin
    in_e       = '0;
    in_e.pc    = iw_pc;
    in_e.instr = iw_instr;
    in_e.dec   = DEC_W'(dec_s);
    in_e.ill   = ill_s;
  end

  assign vld = (st_q != OCC_EMPTY);

  // rdy_q is low in reset and in FULL; without a skid the
  // stage can also take a word when the held one retires
  assign ow_ready = (SKID_EN != 0) ? rdy_q
                  : rdy_q & (!vld | iw_ready);

  assign acc = iw_valid & ow_ready;
  assign ret = vld & iw_ready;

  always_comb begin
    st_d     = st_q;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    pop_skid = 1'b0;
    if (iw_flush) begin
      st_d = OCC_EMPTY;
    end else begin
      unique case (st_q)
        OCC_EMPTY: begin
          if (acc) begin
            ld_out = 1'b1;
            st_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && ret) begin
            ld_out = 1'b1;
          end else if (acc && SKID_EN != 0) begin
            ld_skid = 1'b1;
            st_d    = OCC_FULL;
          end else if (ret) begin
            st_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (ret) begin
            pop_skid = 1'b1;
            st_d     = OCC_ONE;
          end
        end
        default: st_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      st_q   <= OCC_EMPTY;
      rdy_q  <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      st_q  <= st_d;
      rdy_q <= (st_d != OCC_FULL);
      if (ld_out) begin
        out_q <= in_e;
      end else if (pop_skid) begin
        out_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_e;
      end
    end
  end

  assign bub_inc = !vld & iw_ready & !iw_flush
                 & (cnt_q != {CNT_W{1'b1}});

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      cnt_q <= '0;
    end else if (bub_inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ow_bubble_cnt = cnt_q;
  assign ow_valid      = vld;

  // empty slot reads as an all-zero NOP
  assign ow_pc      = vld ? out_q.pc    : '0;
  assign ow_instr   = vld ? out_q.instr : '0;
  assign ow_dec     = vld ? out_q.dec   : '0;
  assign ow_illegal = vld ? out_q.ill   : 1'b0;

endmodule

// File: tb/tb_stg2id_hs.sv
// tb_stg2id_hs: directed self-checking bench for stg2id_hs
// (SKID_EN=1, CNT_W=4).
module tb_stg2id_hs;
  import stg2id_hs_pkg::*;

  localparam int AW = SIZE_ADDR;
  localparam int DW = SIZE_DATA;
  localparam int CW = 4;

  logic          iw_clk;
  logic          iw_rst_n;
  logic          iw_valid;
  logic          ow_ready;
  logic [AW-1:0] iw_pc;
  logic [DW-1:0] iw_instr;
  logic          ow_valid;
  logic          iw_ready;
  logic [AW-1:0] ow_pc;
  logic [DW-1:0] ow_instr;
  logic [SIZE_DEC-1:0] ow_dec;
  logic          ow_illegal;
  logic          iw_flush;
  logic [CW-1:0] ow_bubble_cnt;

  dec_t d;
  assign d = ow_dec;

  int n_cmp = 0;
  int n_bad = 0;

  stg2id_hs #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEC_W  (SIZE_DEC),
    .SKID_EN(1),
    .CNT_W  (CW)
  ) dut (
    .iw_clk       (iw_clk),
    .iw_rst_n     (iw_rst_n),
    .iw_valid     (iw_valid),
    .ow_ready     (ow_ready),
    .iw_pc        (iw_pc),
    .iw_instr     (iw_instr),
    .ow_valid     (ow_valid),
    .iw_ready     (iw_ready),
    .ow_pc        (ow_pc),
    .ow_instr     (ow_instr),
    .ow_dec       (ow_dec),
    .ow_illegal   (ow_illegal),
    .iw_flush     (iw_flush),
    .ow_bubble_cnt(ow_bubble_cnt)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic [11:0] imm);
    return {op, rd, rs, 4'h0, imm};
  endfunction

  task automatic push(input logic [31:0] pc,
                      input logic [31:0] ins);
    iw_valid = 1'b1;
    iw_pc    = pc;
    iw_instr = ins;
    tick();
    iw_valid = 1'b0;
  endtask

  int idx, nlow, nret, unstable, seen;
  logic prev_stall;
  logic [31:0] prev_pc, prev_ins;
  logic [31:0] got [4];

  initial begin
    iw_rst_n = 1'b0;
    iw_valid = 1'b0;
    iw_ready = 1'b0;
    iw_flush = 1'b0;
    iw_pc    = '0;
    iw_instr = '0;

    // reset state
    #12;
    chk("rst_valid", ow_valid, 0);
    chk("rst_ready", ow_ready, 0);
    chk("rst_pc", ow_pc, 0);
    chk("rst_dec", ow_dec, 0);
    chk("rst_cnt", ow_bubble_cnt, 0);
    @(negedge iw_clk);
    iw_rst_n = 1'b1;
    tick();
    chk("rel_ready", ow_ready, 1);
    chk("rel_cnt", ow_bubble_cnt, 0);

    // bubble counter: 3 idle, 2 flush, then saturate
    iw_ready = 1'b1;
    repeat (3) tick();
    chk("bub_3", ow_bubble_cnt, 3);
    iw_flush = 1'b1;
    repeat (2) tick();
    iw_flush = 1'b0;
    chk("bub_flush", ow_bubble_cnt, 3);
    repeat (12) tick();
    chk("bub_15", ow_bubble_cnt, 15);
    repeat (4) tick();
    chk("bub_sat", ow_bubble_cnt, 15);

    // ADDi r3, 0x05A
    push(32'h100, mk_i(OPC_I_ADDi, 5'd3, 5'd0, 12'h05A));
    chk("addi_valid", ow_valid, 1);
    chk("addi_pc", ow_pc, 32'h100);
    chk("addi_imm_en", d.imm_en, 1);
    chk("addi_imm", d.imm_val, 12'h05A);
    chk("addi_tgt", d.tgt_gp, 3);
    chk("addi_we", d.tgt_gp_we, 1);
    chk("addi_sgn", d.sgn_en, 0);
    chk("addi_src", d.src_gp, 0);
    chk("addi_ill", ow_illegal, 0);
    tick();
    chk("addi_ret", ow_valid, 0);

    // stream of 4 with one stall cycle
    idx = 0; nlow = 0; nret = 0;
    unstable = 0; prev_stall = 1'b0;
    prev_pc = '0; prev_ins = '0;
    for (int c = 0; c < 10; c++) begin
      iw_ready = (c != 2);
      iw_valid = (idx < 4);
      iw_pc    = 32'h200 + 32'(4 * idx);
      iw_instr = mk_i(OPC_I_ADDi, 5'(idx + 1), 5'd0, 12'(idx));
      #2;
      if (prev_stall && (ow_pc != prev_pc || ow_instr != prev_ins))
        unstable++;
      if (!ow_ready) nlow++;
      if (ow_valid && iw_ready && nret < 4) begin
        got[nret] = ow_pc;
        nret++;
      end
      prev_stall = ow_valid && !iw_ready;
      prev_pc    = ow_pc;
      prev_ins   = ow_instr;
      if (iw_valid && ow_ready) idx++;
      tick();
    end
    iw_valid = 1'b0;
    chk("strm_nret", nret, 4);
    for (int i = 0; i < 4; i++)
      chk("strm_order", got[i], 32'h200 + 32'(4 * i));
    chk("strm_rdy_low", nlow, 1);
    chk("strm_stable", unstable, 0);
    chk("strm_empty", ow_valid, 0);

    // CMPi r7, 0x123
    iw_ready = 1'b0;
    push(32'h300, mk_i(OPC_I_CMPi, 5'd7, 5'd0, 12'h123));
    chk("cmpi_tgt", d.tgt_gp, 7);
    chk("cmpi_we", d.tgt_gp_we, 0);
    chk("cmpi_imm", d.imm_val, 12'h123);
    iw_ready = 1'b1; tick(); iw_ready = 1'b0;

    // SRJCC cc=A src_sr=5 immsr=BEEF
    push(32'h304, {OPC_S_SRJCC, 4'hA, 3'd0, 3'd5, 16'hBEEF});
    chk("jcc_immsr", d.immsr_val, 16'hBEEF);
    chk("jcc_cc", d.cc, 4'hA);
    chk("jcc_srcsr", d.src_sr, 5);
    chk("jcc_imm", d.imm_val, 0);
    chk("jcc_imm_en", d.imm_en, 0);
    chk("jcc_tgt", d.tgt_gp, 0);
    iw_ready = 1'b1; tick(); iw_ready = 1'b0;

    // undefined opcode
    push(32'h308, {6'h3F, 26'h3FFFFFF});
    chk("ill_valid", ow_valid, 1);
    chk("ill_flag", ow_illegal, 1);
    chk("ill_dec", ow_dec, 0);
    iw_ready = 1'b1; tick(); iw_ready = 1'b0;
    chk("nop_dec", ow_dec, 0);
    chk("nop_pc", ow_pc, 0);

    // flush from ONE with accept and retire pending
    push(32'h400, mk_i(OPC_R_ADD, 5'd1, 5'd2, 12'h0));
    iw_flush = 1'b1; iw_valid = 1'b1;
    iw_pc = 32'h404; iw_ready = 1'b1;
    tick();
    iw_flush = 1'b0; iw_valid = 1'b0;
    chk("fl1_valid", ow_valid, 0);
    chk("fl1_ready", ow_ready, 1);

    // flush from FULL
    iw_ready = 1'b0;
    push(32'h500, mk_i(OPC_R_SUB, 5'd1, 5'd2, 12'h0));
    push(32'h504, mk_i(OPC_R_SUB, 5'd3, 5'd4, 12'h0));
    chk("full_ready", ow_ready, 0);
    iw_flush = 1'b1; iw_valid = 1'b1;
    iw_pc = 32'h508; iw_ready = 1'b1;
    tick();
    iw_flush = 1'b0; iw_valid = 1'b0;
    chk("fl2_valid", ow_valid, 0);
    chk("fl2_ready", ow_ready, 1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (ow_valid) seen++;
      tick();
    end
    chk("fl2_no_leak", seen, 0);

    // async reset while FULL
    iw_ready = 1'b0;
    push(32'h600, mk_i(OPC_R_ADD, 5'd5, 5'd6, 12'h0));
    push(32'h604, mk_i(OPC_R_ADD, 5'd7, 5'd8, 12'h0));
    chk("ar_full", ow_ready, 0);
    #2;
    iw_rst_n = 1'b0;
    #1;
    chk("ar_valid", ow_valid, 0);
    chk("ar_ready", ow_ready, 0);
    chk("ar_pc", ow_pc, 0);
    chk("ar_cnt", ow_bubble_cnt, 0);
    #1;
    iw_rst_n = 1'b1;
    tick();
    chk("ar_rel_ready", ow_ready, 1);
    chk("ar_rel_valid", ow_valid, 0);
    iw_ready = 1'b1;
    push(32'h700, mk_i(OPC_I_ADDi, 5'd1, 5'd0, 12'h001));
    chk("ar_new_valid", ow_valid, 1);
    chk("ar_new_pc", ow_pc, 32'h700);
    tick();
    chk("ar_no_skid", ow_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
